// File: rtl/w0rm_data_bus_ram.sv
// Word-addressed data RAM behind a simple request/response bus with a fixed
// response latency of WAIT_STATES+1 cycles, error responses and overrun flag.
module w0rm_data_bus_ram #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_write_in,
    input  logic                  bus_read_in,
    input  logic                  bus_valid_in,
    input  logic [ADDR_WIDTH-1:0] bus_addr_in,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_valid_out,
    output logic                  bus_error_out,
    output logic                  busy,
    output logic                  overrun_out
);

    localparam int       DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;

    logic                    r_op_wr;
    logic                    r_op_err;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    r_err_out;
    logic [DATA_WIDTH-1:0]   r_data_hold;
    logic                    r_overrun;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_ram_q;

    logic                    w_req;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_in_range;
    logic                    w_misaligned;
    logic                    w_in_err;
    logic [DEPTH_LOG2-1:0]   w_in_idx;

    logic                    w_cur_wr;
    logic                    w_cur_err;
    logic [DEPTH_LOG2-1:0]   w_cur_idx;
    logic [DATA_WIDTH-1:0]   w_cur_wdata;
    logic                    w_enter_resp;
    logic                    w_ram_we;
    logic [DATA_WIDTH-1:0]   w_resp_data;

    // Request decode on the live bus fields (used at the capturing edge)
    assign w_req        = bus_valid_in & (bus_write_in | bus_read_in);
    assign w_accept     = (r_state == IDLE) & w_req;
    assign w_offset     = bus_addr_in - BASE_ADDR;
    assign w_in_range   = ((w_offset >> (DEPTH_LOG2 + 2)) == '0);
    assign w_misaligned = (bus_addr_in[1:0] != 2'b00);
    assign w_in_err     = (bus_write_in & bus_read_in) | w_misaligned | ~w_in_range;
    assign w_in_idx     = w_offset[DEPTH_LOG2+1:2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = WS4;
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // With zero wait states the RAM is addressed straight from the bus in IDLE
    assign w_cur_wr     = (r_state == IDLE) ? (bus_write_in & ~bus_read_in) : r_op_wr;
    assign w_cur_err    = (r_state == IDLE) ? w_in_err    : r_op_err;
    assign w_cur_idx    = (r_state == IDLE) ? w_in_idx    : r_idx;
    assign w_cur_wdata  = (r_state == IDLE) ? bus_data_in : r_wdata;
    assign w_enter_resp = (w_state_next == RESP) & (r_state != RESP);
    assign w_ram_we     = w_enter_resp & w_cur_wr & ~w_cur_err & rst_n;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
        r_ram_q <= r_mem[w_cur_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op_wr     <= 1'b0;
            r_op_err    <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_err_out   <= 1'b0;
            r_data_hold <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_op_wr  <= bus_write_in & ~bus_read_in;
                r_op_err <= w_in_err;
                r_idx    <= w_in_idx;
                r_wdata  <= bus_data_in;
            end
            if (w_enter_resp) begin
                r_err_out <= w_cur_err;
            end
            if (r_state == RESP) begin
                r_data_hold <= w_resp_data;
            end
            if (w_req && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Only a clean read returns RAM data; writes and errors answer with zero
    assign w_resp_data   = (r_op_wr | r_op_err) ? '0 : r_ram_q;
    assign bus_data_out  = (r_state == RESP) ? w_resp_data : r_data_hold;
    assign bus_valid_out = (r_state == RESP);
    assign bus_error_out = r_err_out;
    assign busy          = (r_state != IDLE);
    assign overrun_out   = r_overrun;

endmodule

// File: doc/w0rm_data_bus_ram.md
W0RM_DATA_BUS_RAM -- requirements
Module: w0rm_data_bus_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, log2 of RAM depth in words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of RAM word 0.
REQ-005 SHALL have parameter WAIT_STATES, default 1, extra response cycles (range 0-15).
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port bus_write_in, input, 1, write request (from memory stage data_bus_write_out).
REQ-010 SHALL have port bus_read_in, input, 1, read request.
REQ-011 SHALL have port bus_valid_in, input, 1, request strobe; request fields valid when high.
REQ-012 SHALL have port bus_addr_in, input, ADDR_WIDTH, byte address.
REQ-013 SHALL have port bus_data_in, input, DATA_WIDTH, write data.
REQ-014 SHALL have port bus_data_out, output, DATA_WIDTH, read result (to memory stage data_bus_data_in).
REQ-015 SHALL have port bus_valid_out, output, 1, one-cycle response strobe (to memory stage data_bus_valid_in).
REQ-016 SHALL have port bus_error_out, output, 1, qualifies current response as failed.
REQ-017 SHALL have port busy, output, 1, high while a request is in progress.
REQ-018 SHALL have port overrun_out, output, 1, sticky flag: request dropped while busy.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-020 In IDLE, bus_valid_in high with exactly one of write/read high SHALL capture addr, data, op and enter WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-021 In IDLE, bus_valid_in high with neither write nor read SHALL be ignored; no response.
REQ-022 In IDLE, bus_valid_in high with both write and read SHALL be captured and answered as error; no RAM write.
REQ-023 WAIT SHALL count WAIT_STATES cycles with a 4-bit down-counter, then enter RESP.
REQ-024 RESP SHALL last one cycle, assert bus_valid_out, then return to IDLE.
REQ-025 Latency: bus_valid_out SHALL be high exactly WAIT_STATES+1 cycles after the capturing edge, for one cycle.
REQ-026 Offset = addr - BASE_ADDR (ADDR_WIDTH modulo); in range iff offset < 4*2^DEPTH_LOG2; word index = offset[DEPTH_LOG2+1:2].
REQ-027 addr[1:0] != 0 or out of range SHALL give error response, no RAM access, bus_data_out = 0.
REQ-028 Valid write SHALL update RAM on the edge entering RESP; response bus_data_out = 0, bus_error_out = 0.
REQ-029 Valid read SHALL present RAM word on bus_data_out with bus_valid_out; bus_error_out = 0.
REQ-030 bus_data_out and bus_error_out SHALL hold their values until the next response.
REQ-031 busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-032 bus_valid_in high with write or read while busy SHALL be dropped and set overrun_out; in-flight request unaffected.
REQ-033 Read after write to same word SHALL return the newly written data.
REQ-034 Highest word (offset 4*2^DEPTH_LOG2-4) SHALL be accessible; next word SHALL error.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, counter 0, bus_valid_out 0, bus_error_out 0, bus_data_out 0, busy 0, overrun_out 0.
REQ-036 Reset mid-operation SHALL abort the request: no RAM write, no response after release.
REQ-037 RAM contents SHALL NOT be reset; contents are unspecified before first write.
REQ-038 First request SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-039 WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> each bus_valid_out exactly 2 cycles after capture; read data 0xDEADBEEF, error 0.
REQ-040 Read 0x12 (misaligned), then read 0x1000 with DEPTH_LOG2=10 -> both error=1, data 0; read 0xFFC -> error 0.
REQ-041 Read 0x20 requested while busy with write to 0x24 -> overrun_out=1 sticky; only one response; 0x20 request discarded.
REQ-042 Write 0x12345678 to 0x30, rst_n low during WAIT, release, read 0x30 -> no response to write; read data not 0x12345678 unless previously written.
REQ-043 WAIT_STATES=0, BASE_ADDR=0x8000: back-to-back write/read 0x8004 issued once busy falls -> responses 1 cycle after each capture, read data matches; read 0x7FFC -> error.
REQ-044 bus_valid_in with write=read=1 at 0x40 -> error response, subsequent read 0x40 returns prior contents.
